// File: rtl/cpu_ctrl_pkg.sv
// Shared control-flow definitions: op codes, sequencer states and fault codes
// used by the call/return sequencer and its neighbours in the core.
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        OP_NEXT = 3'd0,
        OP_JUMP = 3'd1,
        OP_CALL = 3'd2,
        OP_RET  = 3'd3,
        OP_HALT = 3'd4
    } op_e;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_RET_WAIT = 2'd1,
        ST_HALTED   = 2'd2,
        ST_FAULT    = 2'd3
    } seq_state_e;

    typedef enum logic [1:0] {
        FC_NONE      = 2'd0,
        FC_OVERFLOW  = 2'd1,
        FC_UNDERFLOW = 2'd2,
        FC_ILLEGAL   = 2'd3
    } fault_code_e;

endpackage

// File: rtl/call_depth_counter.sv
// Tracks live call-stack entries (0..2**STACK_PTR_WIDTH); saturates at both ends
// so occupancy never wraps.
module call_depth_counter #(
    parameter int STACK_PTR_WIDTH = 6
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     inc,
    input  logic                     dec,
    output logic [STACK_PTR_WIDTH:0] depth,
    output logic                     full,
    output logic                     empty
);

    localparam logic [STACK_PTR_WIDTH:0] CAPACITY = {1'b1, {STACK_PTR_WIDTH{1'b0}}};
    localparam logic [STACK_PTR_WIDTH:0] ONE      = {{STACK_PTR_WIDTH{1'b0}}, 1'b1};

    assign full  = (depth == CAPACITY);
    assign empty = (depth == '0);

    // NOTE: sequential state is updated only with non-blocking assignments so
    // every flop samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            depth <= '0;
        end else if (inc && !dec && !full) begin
            depth <= depth + ONE;
        end else if (dec && !inc && !empty) begin
            depth <= depth - ONE;
        end
    end

endmodule

// File: rtl/call_ret_sequencer.sv
// Program-counter sequencer for NEXT/JUMP/CALL/RET/HALT; drives an external
// LIFO call stack and tracks its depth, faulting on overflow/underflow/illegal ops.
module call_ret_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int INSTRUCTION_ADDR_SIZE = 10,
    parameter int STACK_PTR_WIDTH       = 6,
    parameter logic [INSTRUCTION_ADDR_SIZE-1:0] RESET_PC = '0
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             op_valid,
    output logic                             op_ready,
    input  logic [2:0]                       op_code,
    input  logic [INSTRUCTION_ADDR_SIZE-1:0] op_target,
    output logic [INSTRUCTION_ADDR_SIZE-1:0] pc,
    output logic                             pc_valid,
    output logic                             stack_en,
    output logic                             stack_push,
    output logic [INSTRUCTION_ADDR_SIZE-1:0] stack_addr,
    input  logic [INSTRUCTION_ADDR_SIZE-1:0] stack_out,
    output logic [STACK_PTR_WIDTH:0]         depth,
    output logic                             fault,
    output logic [1:0]                       fault_code,
    output logic                             halted
);

    localparam int IAS = INSTRUCTION_ADDR_SIZE;
    localparam logic [IAS-1:0] PC_ONE = {{(IAS-1){1'b0}}, 1'b1};

    seq_state_e     state;
    logic           accept;
    logic           is_full;
    logic           is_empty;
    logic           do_call;
    logic           do_ret;
    logic [IAS-1:0] pc_inc;

    assign op_ready = (state == ST_RUN);
    assign pc_valid = (state == ST_RUN);
    assign accept   = op_valid && op_ready;
    assign pc_inc   = pc + PC_ONE;

    call_depth_counter #(
        .STACK_PTR_WIDTH(STACK_PTR_WIDTH)
    ) u_depth (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (do_call),
        .dec   (do_ret),
        .depth (depth),
        .full  (is_full),
        .empty (is_empty)
    );

    // Stack strobes are combinational so the push/pop lands in the accept cycle.
    always_comb begin
        // NOTE: every output gets a default first, so no path leaves a value
        // held and no latch is inferred.
        stack_en   = 1'b0;
        stack_push = 1'b0;
        stack_addr = '0;
        do_call    = 1'b0;
        do_ret     = 1'b0;
        if (accept) begin
            case (op_code)
                OP_CALL: begin
                    if (!is_full) begin
                        do_call    = 1'b1;
                        stack_en   = 1'b1;
                        stack_push = 1'b1;
                        stack_addr = pc_inc;
                    end
                end
                OP_RET: begin
                    if (!is_empty) begin
                        do_ret   = 1'b1;
                        stack_en = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_RUN;
            pc         <= RESET_PC;
            fault      <= 1'b0;
            fault_code <= FC_NONE;
            halted     <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (accept) begin
                        case (op_code)
                            OP_NEXT: pc <= pc_inc;
                            OP_JUMP: pc <= op_target;
                            OP_CALL: begin
                                if (is_full) begin
                                    state      <= ST_FAULT;
                                    fault      <= 1'b1;
                                    fault_code <= FC_OVERFLOW;
                                end else begin
                                    pc <= op_target;
                                end
                            end
                            OP_RET: begin
                                if (is_empty) begin
                                    state      <= ST_FAULT;
                                    fault      <= 1'b1;
                                    fault_code <= FC_UNDERFLOW;
                                end else begin
                                    state <= ST_RET_WAIT;
                                end
                            end
                            OP_HALT: begin
                                state  <= ST_HALTED;
                                halted <= 1'b1;
                            end
                            default: begin
                                state      <= ST_FAULT;
                                fault      <= 1'b1;
                                fault_code <= FC_ILLEGAL;
                            end
                        endcase
                    end
                end
                // Popped return address is valid one cycle after the pop strobe.
                ST_RET_WAIT: begin
                    pc    <= stack_out;
                    state <= ST_RUN;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_call_ret_sequencer.sv
// Directed bench for call_ret_sequencer with a behavioural LIFO call stack and
// a scoreboard of expected post-edge architectural state.
module tb_call_ret_sequencer;
    import cpu_ctrl_pkg::*;

    typedef struct packed {
        logic [9:0] pc;
        logic [6:0] depth;
        logic       valid;
        logic       fault;
        logic [1:0] fc;
        logic       halted;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       op_valid;
    logic       op_ready;
    logic [2:0] op_code;
    logic [9:0] op_target;
    logic [9:0] pc;
    logic       pc_valid;
    logic       stack_en;
    logic       stack_push;
    logic [9:0] stack_addr;
    logic [9:0] stack_out = '0;
    logic [6:0] depth;
    logic       fault;
    logic [1:0] fault_code;
    logic       halted;

    int   tests = 0;
    int   fails = 0;
    exp_t sb[$];
    logic [9:0] stk[$];
    logic [9:0] cur_pc;
    logic [9:0] tgt;

    always #5 clk = ~clk;

    call_ret_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .op_valid   (op_valid),
        .op_ready   (op_ready),
        .op_code    (op_code),
        .op_target  (op_target),
        .pc         (pc),
        .pc_valid   (pc_valid),
        .stack_en   (stack_en),
        .stack_push (stack_push),
        .stack_addr (stack_addr),
        .stack_out  (stack_out),
        .depth      (depth),
        .fault      (fault),
        .fault_code (fault_code),
        .halted     (halted)
    );

    // Behavioural call stack: push stores addr, pop presents top on the next cycle.
    always @(posedge clk) begin
        if (stack_en) begin
            if (stack_push) stk.push_back(stack_addr);
            else if (stk.size() > 0) stack_out <= stk.pop_back();
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t ex(input logic [9:0] p, input logic [6:0] d, input logic v,
                                input logic f, input logic [1:0] c, input logic h);
        exp_t e;
        e.pc = p; e.depth = d; e.valid = v; e.fault = f; e.fc = c; e.halted = h;
        return e;
    endfunction

    task automatic step(input logic v, input logic [2:0] c, input logic [9:0] t,
                        input logic x_en, input logic x_push, input logic [9:0] x_addr,
                        input exp_t x);
        exp_t e;
        @(negedge clk);
        op_valid = v; op_code = c; op_target = t;
        #1;
        check("stack_en", stack_en, x_en);
        check("stack_push", stack_push, x_push);
        check("stack_addr", stack_addr, x_addr);
        sb.push_back(x);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("pc", pc, e.pc);
        check("depth", depth, e.depth);
        check("pc_valid", pc_valid, e.valid);
        check("op_ready", op_ready, e.valid);
        check("fault", fault, e.fault);
        check("fault_code", fault_code, e.fc);
        check("halted", halted, e.halted);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; op_valid = 1'b0;
        #1;
        check("rst_pc", pc, 10'd0);
        check("rst_depth", depth, 7'd0);
        check("rst_ready", op_ready, 1'b1);
        check("rst_fault", fault, 1'b0);
        check("rst_fc", fault_code, 2'd0);
        check("rst_halted", halted, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b1; op_valid = 1'b0; op_code = '0; op_target = '0;
        do_reset();

        // Straight-line sequencing
        step(1, OP_NEXT, 0, 0, 0, 0, ex(10'd1, 0, 1, 0, 0, 0));
        step(1, OP_NEXT, 0, 0, 0, 0, ex(10'd2, 0, 1, 0, 0, 0));
        step(1, OP_NEXT, 0, 0, 0, 0, ex(10'd3, 0, 1, 0, 0, 0));

        // Single call/return with one bubble
        step(1, OP_JUMP, 10'd5, 0, 0, 0, ex(10'd5, 0, 1, 0, 0, 0));
        step(1, OP_CALL, 10'd67, 1, 1, 10'd6, ex(10'd67, 1, 1, 0, 0, 0));
        step(1, OP_RET, 0, 1, 0, 0, ex(10'd67, 0, 0, 0, 0, 0));
        step(0, OP_NEXT, 0, 0, 0, 0, ex(10'd6, 0, 1, 0, 0, 0));

        // Nested calls
        step(1, OP_CALL, 10'd41, 1, 1, 10'd7, ex(10'd41, 1, 1, 0, 0, 0));
        step(1, OP_CALL, 10'd21, 1, 1, 10'd42, ex(10'd21, 2, 1, 0, 0, 0));
        step(1, OP_RET, 0, 1, 0, 0, ex(10'd21, 1, 0, 0, 0, 0));
        step(0, OP_NEXT, 0, 0, 0, 0, ex(10'd42, 1, 1, 0, 0, 0));
        step(1, OP_RET, 0, 1, 0, 0, ex(10'd42, 0, 0, 0, 0, 0));
        step(0, OP_NEXT, 0, 0, 0, 0, ex(10'd7, 0, 1, 0, 0, 0));

        // Op without valid is ignored
        step(0, OP_JUMP, 10'd100, 0, 0, 0, ex(10'd7, 0, 1, 0, 0, 0));

        // PC wrap
        step(1, OP_JUMP, 10'd1023, 0, 0, 0, ex(10'd1023, 0, 1, 0, 0, 0));
        step(1, OP_NEXT, 0, 0, 0, 0, ex(10'd0, 0, 1, 0, 0, 0));

        // Reset while a return is pending
        step(1, OP_CALL, 10'd300, 1, 1, 10'd1, ex(10'd300, 1, 1, 0, 0, 0));
        step(1, OP_RET, 0, 1, 0, 0, ex(10'd300, 0, 0, 0, 0, 0));
        do_reset();
        step(1, OP_NEXT, 0, 0, 0, 0, ex(10'd1, 0, 1, 0, 0, 0));

        // Underflow is sticky and blocks later ops
        step(1, OP_RET, 0, 0, 0, 0, ex(10'd1, 0, 0, 1, 2'd2, 0));
        step(1, OP_NEXT, 0, 0, 0, 0, ex(10'd1, 0, 0, 1, 2'd2, 0));
        do_reset();

        // Fill the stack, then overflow on the 65th call
        cur_pc = 10'd0;
        for (int i = 0; i < 64; i++) begin
            tgt = 10'(100 + 3 * i);
            step(1, OP_CALL, tgt, 1, 1, cur_pc + 10'd1, ex(tgt, 7'(i + 1), 1, 0, 0, 0));
            cur_pc = tgt;
        end
        step(1, OP_CALL, 10'd999, 0, 0, 0, ex(cur_pc, 7'd64, 0, 1, 2'd1, 0));
        step(1, OP_RET, 0, 0, 0, 0, ex(cur_pc, 7'd64, 0, 1, 2'd1, 0));
        do_reset();

        // Illegal op codes
        step(1, 3'd5, 10'd9, 0, 0, 0, ex(10'd0, 0, 0, 1, 2'd3, 0));
        do_reset();
        step(1, OP_CALL, 10'd50, 1, 1, 10'd1, ex(10'd50, 1, 1, 0, 0, 0));
        step(1, 3'd7, 10'd9, 0, 0, 0, ex(10'd50, 1, 0, 1, 2'd3, 0));
        do_reset();

        // Halt freezes the PC
        step(1, OP_NEXT, 0, 0, 0, 0, ex(10'd1, 0, 1, 0, 0, 0));
        step(1, OP_HALT, 0, 0, 0, 0, ex(10'd1, 0, 0, 0, 0, 1));
        step(1, OP_CALL, 10'd3, 0, 0, 0, ex(10'd1, 0, 0, 0, 0, 1));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
